// File: rtl/sdram_ctrl_pkg.sv
// Shared definitions for the row access controller: geometry and FSM states.
package sdram_ctrl_pkg;

    localparam int ROW_BITS  = 8;
    localparam int NUM_ROWS  = 256;
    localparam int ROW_WIDTH = 2048;

    // Controller phases: idle, precharge pulse, activate pulse, response strobe.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PRE  = 2'd1,
        ST_ACT  = 2'd2,
        ST_RESP = 2'd3
    } state_e;

endpackage

// File: rtl/row_decoder.sv
// Row index to one-hot word-line select; all-zero when not enabled.
module row_decoder
    import sdram_ctrl_pkg::*;
(
    input  logic                en_i,
    input  logic [ROW_BITS-1:0] idx_i,
    output logic [NUM_ROWS-1:0] onehot_o
);

    // One-hot decode gated by the enable.
    always_comb begin
        onehot_o = '0;
        if (en_i) begin
            onehot_o[idx_i] = 1'b1;
        end
    end

endmodule

// File: rtl/row_access_ctrl.sv
// Single-bank row access controller: writes precharge the addressed row with
// the write data (closing the open row), read misses activate the row and
// capture it into a local row buffer, read hits answer straight from it.
module row_access_ctrl
    import sdram_ctrl_pkg::*;
#(
    parameter int T_RP  = 2,
    parameter int T_RCD = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_write,
    input  logic [ROW_BITS-1:0]  req_row,
    input  logic [ROW_WIDTH-1:0] req_wdata,
    output logic                 rsp_valid,
    output logic [ROW_WIDTH-1:0] rsp_rdata,
    output logic                 mem_precharge,
    output logic                 mem_activate,
    output logic [NUM_ROWS-1:0]  mem_row_addr,
    output logic [ROW_WIDTH-1:0] mem_row_in,
    input  logic [ROW_WIDTH-1:0] mem_row_out
);

    // Counter holds (pulse length - 1) down to 0, so it only needs to reach T_MAX-1.
    localparam int T_MAX = (T_RP > T_RCD) ? T_RP : T_RCD;
    localparam int CNT_W = (T_MAX > 1) ? $clog2(T_MAX) : 1;

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [ROW_BITS-1:0]  row_q, row_d;
    logic                 wr_q, wr_d;
    logic [ROW_WIDTH-1:0] wdata_q, wdata_d;
    logic [ROW_WIDTH-1:0] rowbuf_q, rowbuf_d;
    logic [ROW_BITS-1:0]  open_row_q, open_row_d;
    logic                 open_valid_q, open_valid_d;

    logic in_pre, in_act, hit;

    assign in_pre = (state_q == ST_PRE);
    assign in_act = (state_q == ST_ACT);
    assign hit    = open_valid_q && (req_row == open_row_q);

    // Next-state logic: latch the request in IDLE, time the pulses, update the open row.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        row_d        = row_q;
        wr_d         = wr_q;
        wdata_d      = wdata_q;
        rowbuf_d     = rowbuf_q;
        open_row_d   = open_row_q;
        open_valid_d = open_valid_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    row_d   = req_row;
                    wr_d    = req_write;
                    wdata_d = req_wdata;
                    if (req_write) begin
                        state_d = ST_PRE;
                        cnt_d   = CNT_W'(T_RP - 1);
                    end else if (hit) begin
                        state_d = ST_RESP;
                        cnt_d   = '0;
                    end else begin
                        state_d = ST_ACT;
                        cnt_d   = CNT_W'(T_RCD - 1);
                    end
                end
            end
            ST_PRE: begin
                if (cnt_q == '0) begin
                    // Precharge closes the bank, so nothing is open afterwards.
                    open_valid_d = 1'b0;
                    state_d      = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_ACT: begin
                if (cnt_q == '0) begin
                    rowbuf_d     = mem_row_out;
                    open_row_d   = row_q;
                    open_valid_d = 1'b1;
                    state_d      = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State registers; reset aborts any in-flight access in the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            row_q        <= '0;
            wr_q         <= 1'b0;
            wdata_q      <= '0;
            rowbuf_q     <= '0;
            open_row_q   <= '0;
            open_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            row_q        <= row_d;
            wr_q         <= wr_d;
            wdata_q      <= wdata_d;
            rowbuf_q     <= rowbuf_d;
            open_row_q   <= open_row_d;
            open_valid_q <= open_valid_d;
        end
    end

    row_decoder u_dec (
        .en_i     (in_pre | in_act),
        .idx_i    (row_q),
        .onehot_o (mem_row_addr)
    );

    assign req_ready     = (state_q == ST_IDLE) && !reset;
    assign rsp_valid     = (state_q == ST_RESP);
    assign rsp_rdata     = (rsp_valid && !wr_q) ? rowbuf_q : '0;
    assign mem_precharge = in_pre;
    assign mem_activate  = in_act;
    assign mem_row_in    = in_pre ? wdata_q : '0;

endmodule
